// File: rtl/stack_rd_rsp.sv
// Read-response side of the LIFO stack controller: credit-gated pops, 1-cycle read capture, valid/ready return.
// Optional combinational bypass of an empty response buffer: define Q_STACK_RD_RSP_BYPASS_EN.
module stack_rd_rsp #(
  parameter int W     = 32,
  parameter int BUF_N = 2,
  parameter int CNT_W = $clog2(BUF_N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pop_req,
  output logic         o_pop_gnt,
  input  logic         i_push,
  input  logic         i_empty,
  output logic         o_pop,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_data,
  output logic         o_busy
);

  localparam int PTR_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_N - 1);
  localparam logic [CNT_W:0]   DEPTH    = (CNT_W + 1)'(BUF_N);

  logic             inflight_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic [W-1:0]     mem_r [BUF_N];

  logic             buf_nonempty;
  logic             deq;
  logic             buf_rd;
  logic             buf_wr;
  logic [CNT_W:0]   committed;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    buf_nonempty = (occ_r != '0);
`ifdef Q_STACK_RD_RSP_BYPASS_EN
    // Returning read with an empty buffer is presented directly; it only
    // lands in the buffer if the consumer does not take it this cycle.
    o_rsp_valid = buf_nonempty | inflight_r;
    o_rsp_data  = buf_nonempty ? mem_r[rd_ptr_r] : i_mem_rdata;
    deq         = o_rsp_valid & i_rsp_ready;
    buf_rd      = deq & buf_nonempty;
    buf_wr      = inflight_r & ~(~buf_nonempty & i_rsp_ready);
`else
    o_rsp_valid = buf_nonempty;
    o_rsp_data  = mem_r[rd_ptr_r];
    deq         = o_rsp_valid & i_rsp_ready;
    buf_rd      = deq;
    buf_wr      = inflight_r;
`endif
    // Slots already owed (buffered + in flight) minus the one leaving now.
    committed = {1'b0, occ_r} + (CNT_W + 1)'(inflight_r) - (CNT_W + 1)'(deq);
    // Never pop the stack while in reset: the read would be discarded.
    o_pop     = ~rst & i_pop_req & ~i_empty & ~i_push & (committed < DEPTH);
    o_pop_gnt = o_pop;
    o_busy    = inflight_r | buf_nonempty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      occ_r      <= '0;
    end else begin
      inflight_r <= o_pop;
      if (buf_wr) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (buf_rd) rd_ptr_r <= ptr_inc(rd_ptr_r);
      occ_r <= occ_r + CNT_W'(buf_wr) - CNT_W'(buf_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) mem_r[wr_ptr_r] <= i_mem_rdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ_r} + (CNT_W + 1)'(inflight_r)) <= DEPTH));

endmodule

// File: tb/tb_stack_rd_rsp.sv
// Bench for stack_rd_rsp: directed vector table, streaming sequence, and random traffic against a queue model.
module tb_stack_rd_rsp;
  localparam int W     = 32;
  localparam int BUF_N = 2;
`ifdef Q_STACK_RD_RSP_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst, pop_req, empty, push, rsp_ready;
  logic [W-1:0] mem_rdata;
  logic         pop_gnt, pop, rsp_valid, busy;
  logic [W-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  stack_rd_rsp #(.W(W), .BUF_N(BUF_N)) dut (
    .clk(clk), .rst(rst), .i_pop_req(pop_req), .o_pop_gnt(pop_gnt),
    .i_push(push), .i_empty(empty), .o_pop(pop), .i_mem_rdata(mem_rdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_pop, input bit e_valid,
                            input logic [W-1:0] e_data, input bit e_busy);
    chk({tag, ".pop"}, W'(pop), W'(e_pop));
    chk({tag, ".gnt"}, W'(pop_gnt), W'(e_pop));
    chk({tag, ".valid"}, W'(rsp_valid), W'(e_valid));
    if (e_valid) chk({tag, ".data"}, rsp_data, e_data);
    chk({tag, ".busy"}, W'(busy), W'(e_busy));
  endtask

  typedef struct {
    bit           chk;
    bit           rst, req, empty, push, ready;
    logic [W-1:0] rdata;
    bit           e_pop, e_valid;
    logic [W-1:0] e_data;
    bit           e_busy;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit c, input bit r, input bit rq, input bit em, input bit ps,
                     input bit rdy, input logic [W-1:0] rd, input bit ep, input bit ev,
                     input logic [W-1:0] ed, input bit eb);
    vec_t v;
    v.chk = c; v.rst = r; v.req = rq; v.empty = em; v.push = ps; v.ready = rdy;
    v.rdata = rd; v.e_pop = ep; v.e_valid = ev; v.e_data = ed; v.e_busy = eb;
    tv.push_back(v);
  endtask

  typedef struct {
    int           avail;
    logic [W-1:0] data;
  } ent_t;
  ent_t q[$];

  initial begin
    int  cyc;
    bit  pend_fill;
    bit  e_valid, e_deq, e_pop, e_busy;
    logic [W-1:0] e_data;

    rst = 1'b1; pop_req = 1'b0; empty = 1'b0; push = 1'b0; rsp_ready = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;

`ifndef Q_STACK_RD_RSP_BYPASS_EN
    //   chk rst req emp psh rdy rdata  pop vld data   busy
    add(0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 1, 32'h0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 1, 32'hA5, 0, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 1, 32'hA5, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 0, 32'h11, 1, 0, 32'h0,  1);
    add(1, 0, 1, 0, 0, 0, 32'h22, 0, 1, 32'h11, 1);
    add(1, 0, 1, 0, 0, 0, 32'h99, 0, 1, 32'h11, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 1, 32'h11, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 1, 32'h22, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 1, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 1, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 1, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 1, 32'h0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 1, 32'h33, 0, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 1, 32'h33, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 0, 32'h44, 1, 0, 32'h0,  1);
    add(1, 1, 0, 0, 0, 0, 32'h55, 0, 1, 32'h44, 1);
    add(1, 0, 0, 0, 0, 0, 32'h66, 0, 0, 32'h0,  0);
    add(1, 0, 1, 0, 0, 1, 32'h0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 1, 32'h77, 0, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 1, 32'h77, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; pop_req = tv[i].req; empty = tv[i].empty; push = tv[i].push;
      rsp_ready = tv[i].ready; mem_rdata = tv[i].rdata;
      @(negedge clk);
      if (tv[i].chk)
        check_outs($sformatf("vec%0d", i), tv[i].e_pop, tv[i].e_valid, tv[i].e_data, tv[i].e_busy);
      @(posedge clk); #1;
    end
`endif

    // Streaming: 16 back-to-back pops with ready held high.
    rst = 1'b1; pop_req = 1'b0; rsp_ready = 1'b1; empty = 1'b0; push = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 16 + LAT + 1; c++) begin
      pop_req   = (c < 16);
      mem_rdata = (c >= 1) ? W'(c - 1) : 32'hDEAD_BEEF;
      @(negedge clk);
      check_outs($sformatf("stream%0d", c), (c < 16), (c >= LAT) && (c < 16 + LAT),
                 W'(c - LAT), (c >= 1) && (c <= 15 + LAT));
      @(posedge clk); #1;
    end

    // Random traffic against a queue of owed responses.
    rst = 1'b1; pop_req = 1'b0;
    @(posedge clk); #1;
    q.delete(); pend_fill = 1'b0; cyc = 0;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(99) == 0);
      pop_req   = ($urandom_range(9) < 7);
      empty     = ($urandom_range(9) < 1);
      push      = ($urandom_range(9) < 2);
      rsp_ready = ($urandom_range(9) < 6);
      mem_rdata = $urandom;
      if (pend_fill) q[q.size() - 1].data = mem_rdata;
      e_valid = (q.size() != 0) && (q[0].avail <= cyc);
      e_data  = e_valid ? q[0].data : '0;
      e_deq   = e_valid && rsp_ready;
      e_pop   = !rst && pop_req && !empty && !push && ((q.size() - int'(e_deq)) < BUF_N);
      e_busy  = (q.size() != 0);
      @(negedge clk);
      check_outs($sformatf("rnd%0d", n), e_pop, e_valid, e_data, e_busy);
      @(posedge clk);
      if (rst) begin
        q.delete();
        pend_fill = 1'b0;
      end else begin
        if (e_deq) void'(q.pop_front());
        if (e_pop) q.push_back('{avail: cyc + LAT, data: '0});
        pend_fill = e_pop;
      end
      cyc++;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_rd_rsp.md
# stack_rd_rsp

Read-response side for the LIFO stack controller. Accepts pop requests from a consumer and issues pops to the controller only when buffer space is guaranteed. Captures the single-cycle-latency synchronous memory read data and returns it on a valid/ready stream. Sits between the stack controller/SRAM pair and any downstream consumer, so stack pops never drop data under backpressure.

## Interface
- W, 32, data width of stack entries and response payload.
- BUF_N, 2, response buffer entries; legal range 2..8.
- CNT_W, $clog2(BUF_N + 1), width of occupancy/credit counters.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_pop_req  in  1  consumer requests one pop.
- o_pop_gnt  out  1  request accepted this cycle; equals o_pop.
- i_push  in  1  push presented to the stack controller this cycle.
- i_empty  in  1  registered empty flag of the stack controller.
- o_pop  out  1  pop strobe to the stack controller.
- i_mem_rdata  in  W  memory read data, valid exactly 1 cycle after o_pop.
- o_rsp_valid  out  1  response data valid.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  W  popped entry.
- o_busy  out  1  read in flight or buffer non-empty.

## Operation
- State: inflight_r (1 bit), buffer rd_ptr_r/wr_ptr_r (wrap at BUF_N-1 -> 0), occ_r (0..BUF_N).
- deq = o_rsp_valid & i_rsp_ready.
- o_pop = i_pop_req & ~i_empty & ~i_push & ((occ_r + inflight_r - deq) < BUF_N). Compute at CNT_W+1 bits; no wrap.
- Push has priority: a pop is never issued in a cycle with i_push=1. i_pop_req is then ungranted and the requester retries.
- Pop with i_empty=1 is never granted. No error is flagged.
- inflight_r <= o_pop. When inflight_r=1, i_mem_rdata is captured into the buffer at wr_ptr_r, except when bypassed (see Configuration).
- occ_r next = occ_r + write - deq. A simultaneous write and deq leaves occ_r unchanged and advances both pointers.
- Without bypass: o_rsp_valid = (occ_r != 0); o_rsp_data = buffer[rd_ptr_r].
- Buffer overflow is impossible by construction. occ_r + inflight_r <= BUF_N is an invariant and must be asserted.
- o_busy = inflight_r | (occ_r != 0).
- Reset: inflight_r=0, occ_r=0, pointers=0.
  - o_rsp_valid=0, o_pop=0, o_busy=0 from the cycle after rst.
  - A read in flight at reset is discarded.
  - Buffer data contents are not reset.

## Timing
- Pop issued at cycle t; memory data at t+1.
  - Without bypass: o_rsp_valid at t+2.
  - With bypass and empty buffer: o_rsp_valid at t+1.
- Sustained throughput is 1 response/cycle when i_rsp_ready is held high and BUF_N>=2.
- i_rsp_ready -> o_pop is a combinational path; i_rsp_ready must come from a register.
- o_rsp_valid, once asserted, holds with stable o_rsp_data until deq.

## Configuration
- Macro: Q_STACK_RD_RSP_BYPASS_EN.
- Defined: when inflight_r=1 and occ_r=0:
  - o_rsp_valid=1 and o_rsp_data=i_mem_rdata combinationally.
  - If i_rsp_ready=1, the data is consumed and not written to the buffer.
  - Otherwise it is written and held.
  - Load-to-use is 1 cycle after o_pop.
- Undefined: all responses pass through the buffer. Outputs are register-driven. Load-to-use is 2 cycles after o_pop.

## Test plan
- Reset, then i_pop_req=1 with i_empty=0, i_rsp_ready=1, rdata 0xA5 at t+1 -> o_pop at t.
  - o_rsp_valid/0xA5 at t+2 (t+1 with BYPASS_EN).
  - o_busy deasserts afterward.
- i_rsp_ready=0, i_pop_req held, BUF_N=2, rdata 0x11, 0x22 -> exactly 2 pops granted, then o_pop=0.
  - Release ready -> 0x11 then 0x22 (LIFO data order as returned), each in one cycle.
- i_pop_req=1 with i_empty=1 -> o_pop=0 forever and o_rsp_valid=0. Same with i_empty=0 and i_push=1 -> o_pop=0 that cycle.
- Ready held high, pop every cycle for 16 cycles, rdata 0..15 -> 16 consecutive responses 0..15 with no bubbles after first.
  - Pointers wrap with no loss.
- Assert rst with inflight_r=1 and occ_r=1 -> next cycle o_rsp_valid=0 and o_busy=0.
  - Late rdata ignored; the next pop returns only its own data.
